// File: rtl/countdown_scheduler_pkg.sv
// ============================================================================
// Module      : countdown_scheduler_pkg
// Description : Shared FSM encodings, reset count value and index-width helper
//               for the countdown scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package countdown_scheduler_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        COUNT = ST_COUNT,
        DONE  = ST_DONE
    } state_e;

    localparam int RESET_LOAD = 100;

    // Never returns less than 1 so a 1-bit index exists even for tiny N.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << r) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/countdown_scheduler_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick, searching upward from the slot
//               after last_idx_i and wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import countdown_scheduler_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_idx_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        w_cand  = '0;
        w_found = 1'b0;
        idx_o   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((int'(last_idx_i) + k) % N_REQ);
            if (!w_found && req_i[w_cand]) begin
                w_found = 1'b1;
                idx_o   = w_cand;
            end
        end
        valid_o = w_found;
        grant_o = w_found ? (N_REQ'(1) << idx_o) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/countdown_scheduler.sv
// ============================================================================
// Module      : countdown_scheduler
// Description : Shares one down counter among N_REQ requesters via round-robin
//               arbitration; load, count down, retire and pulse done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_scheduler
    import countdown_scheduler_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int WIDTH        = 10,
    parameter int DEFAULT_LOAD = RESET_LOAD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] load_val_i,
    output logic [N_REQ-1:0]       grant_o,
    output logic                   busy_o,
    output logic [WIDTH-1:0]       count_o,
    output logic [N_REQ-1:0]       done_o
);

    localparam int IDX_W = clog2(N_REQ);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;

    logic [N_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [WIDTH-1:0]   win_load;
    logic [N_REQ-1:0]   win_onehot;

    rr_arbiter #(
        .N_REQ      (N_REQ)
    ) u_arb (
        .req_i      (req_i),
        .last_idx_i (ptr_q),
        .grant_o    (arb_grant),
        .idx_o      (arb_idx),
        .valid_o    (arb_valid)
    );

    assign win_load   = load_val_i[int'(win_q)*WIDTH +: WIDTH];
    assign win_onehot = N_REQ'(1) << win_q;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        grant_d = grant_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    win_d   = arb_idx;
                    grant_d = arb_grant;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = win_load;
                if (win_load == '0) begin
                    done_d  = win_onehot;
                    state_d = DONE;
                end else begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // Abort leaves count frozen and the pointer untouched.
                if (!req_i[win_q]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (count_q <= WIDTH'(1)) begin
                    count_d = '0;
                    done_d  = win_onehot;
                    state_d = DONE;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            DONE: begin
                grant_d = '0;
                done_d  = '0;
                ptr_d   = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            count_q <= WIDTH'(DEFAULT_LOAD);
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign count_o = count_q;
    assign busy_o  = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_countdown_scheduler.sv
// ============================================================================
// Module      : tb_countdown_scheduler
// Description : Self-checking bench: directed scenarios plus random traffic
//               against a timeline-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_scheduler;

    localparam int N = 4;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] load = '0;
    logic [N-1:0]   grant, done;
    logic           busy;
    logic [W-1:0]   count;

    int checks = 0;
    int errors = 0;

    // Reference: a grant is a timeline; t counts edges since the grant.
    bit m_active;
    int m_owner, m_t, m_len, m_cnt, m_ptr;

    always #5 clk = ~clk;

    countdown_scheduler #(
        .N_REQ        (N),
        .WIDTH        (W),
        .DEFAULT_LOAD (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req),
        .load_val_i (load),
        .grant_o    (grant),
        .busy_o     (busy),
        .count_o    (count),
        .done_o     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_t      = 0;
        m_len    = 0;
        m_cnt    = 100;
        m_ptr    = N - 1;
        m_owner  = 0;
    endtask

    task automatic model_step();
        int c;
        if (!m_active) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!m_active && req[c]) begin
                    m_active = 1;
                    m_owner  = c;
                    m_t      = 0;
                end
            end
        end else if (m_t == 0) begin
            m_len = int'(load[m_owner*W +: W]);
            m_cnt = m_len;
            m_t   = 1;
        end else if (m_t == m_len + 1) begin
            m_active = 0;
            m_ptr    = m_owner;
        end else if (!req[m_owner]) begin
            m_active = 0;
        end else begin
            m_cnt = m_cnt - 1;
            m_t   = m_t + 1;
        end
    endtask

    function automatic bit exp_done();
        return m_active && m_t >= 1 && m_t == m_len + 1;
    endfunction

    task automatic compare_all(input string tag);
        logic [N-1:0] eg, ed;
        eg = m_active ? (N'(1) << m_owner) : '0;
        ed = exp_done() ? (N'(1) << m_owner) : '0;
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".done"},  32'(done),  32'(ed));
        check({tag, ".busy"},  32'(busy),  32'(m_active));
        check({tag, ".count"}, 32'(count), 32'(m_cnt));
    endtask

    // Advance one clock: model follows the edge, outputs checked on the negedge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic set_load(input int i, input int v);
        load[i*W +: W] = W'(v);
    endtask

    task automatic drain(input string tag);
        req = '0;
        for (int i = 0; i < 4 && m_active; i++) tick(tag);
        tick(tag);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare_all("reset");
        reset = 1'b0;
        tick("idle");

        // Single requester, length 3
        req = 4'b0100;
        set_load(2, 3);
        repeat (6) tick("single");
        req = '0;
        repeat (2) tick("single");

        // All requesting, length 2: round-robin order
        for (int i = 0; i < N; i++) set_load(i, 2);
        req = 4'b1111;
        repeat (22) tick("rr");
        drain("rr_drain");

        // Zero-length countdown
        req = 4'b0010;
        set_load(1, 0);
        repeat (3) tick("zero");
        req = '0;
        tick("zero");

        // Abort at count 20 with req[0] pending
        set_load(3, 50);
        set_load(0, 4);
        req = 4'b1000;
        tick("abort");
        req = 4'b1001;
        for (int i = 0; i < 60 && !(m_active && m_cnt == 20); i++) tick("abort");
        check("abort.reached20", 32'(count), 32'd20);
        req[3] = 1'b0;
        repeat (10) tick("abort");
        req = '0;
        drain("abort_drain");

        // load_val changed mid-count is ignored
        set_load(0, 5);
        req = 4'b0001;
        repeat (3) tick("resample");
        set_load(0, 9);
        repeat (6) tick("resample");
        req = '0;
        drain("resample_drain");

        // Asynchronous reset mid-count
        set_load(0, 60);
        req = 4'b0001;
        for (int i = 0; i < 40 && !(m_active && m_cnt == 37); i++) tick("preset");
        check("preset.count37", 32'(count), 32'd37);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all("async_reset");
        tick("in_reset");
        reset = 1'b0;
        req = '0;
        tick("post_reset");

        // Random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (exp_done() && m_owner == i) req[i] = 1'($urandom_range(1));
                else if (!req[i] && $urandom_range(3) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(59) == 0) req[i] = 1'b0;
                if ($urandom_range(7) == 0) set_load(i, int'($urandom_range(6)));
            end
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
